minterm_scanner: RTL
====================

// Module: minterm_scanner
// PURPOSE
//  Sequential counterpart of our SoP/PoS function blocks: drives every input combination of an
//  N_VARS-input combinational function and samples its output, then reads back the function's
//  minterm list (mode 0) or maxterm list (mode 1) as a stream of indices.
//  Sits beside any combinational function under test: vars -> function inputs, function output -> f_in.
//  Replaces hand-written truth-table stimulus with an on-chip enumerator and term extractor.
// PARAMETERS
//  N_VARS  4  number of function inputs; indices 0 .. 2**N_VARS-1, MSB of vars = first variable
//  SETTLE  1  cycles each combination is held before f_in is sampled (>=1)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         asynchronous, active-high reset
//  start      in   1         begin a scan; accepted only in IDLE
//  mode       in   1         0 = report indices where f_in==1 (minterms), 1 = where f_in==0 (maxterms)
//  f_in       in   1         output of the function under test
//  vars       out  N_VARS    input combination currently driven to the function
//  idx_valid  out  1         idx holds a reported term index
//  idx        out  N_VARS    reported term index
//  idx_ready  in   1         consumer accepts idx when idx_valid && idx_ready
//  busy       out  1         high from the cycle after start is accepted until done
//  done       out  1         one-cycle pulse at end of scan
//  count      out  N_VARS+1  number of terms reported in the current/last scan
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; vars=0, idx=0, idx_valid=0, busy=0, done=0, count=0.
//  - States: IDLE, DRIVE, EMIT, DONE.
//  - IDLE: start=1 at an edge -> latch mode, m=0, count=0, settle counter=0, vars=0, busy=1 -> DRIVE.
//    start while busy is ignored; mode changes during a scan are ignored (latched copy used).
//  - DRIVE: vars=m held for exactly SETTLE cycles; f_in is sampled at the edge ending the last one.
//    hit = (f_in != latched mode). hit -> idx=m, idx_valid=1 -> EMIT.
//    no hit and m==2**N_VARS-1 -> DONE; no hit otherwise -> m=m+1, settle counter=0, stay DRIVE.
//  - EMIT: idx, idx_valid and vars held stable until idx_valid&&idx_ready; on that edge count+=1,
//    idx_valid=0, then -> DONE if m is last, else m=m+1 -> DRIVE. Min. 1 cycle in EMIT.
//  - DONE: done=1 for one cycle, busy=0, -> IDLE. count and vars keep final values until next start.
//  - Timing, no back-pressure: scan length = 2**N_VARS*SETTLE + hits cycles; done pulses the cycle after.
//  - Widths: m is N_VARS bits, last index detected by compare (no wrap to 0 mid-scan);
//    count is N_VARS+1 bits so all 2**N_VARS terms fit without overflow.
//  - f_in of x/z counts as no hit (sampled value compared with !== semantics disallowed: use ==).
//  - Reset mid-scan (incl. during EMIT with idx_valid=1): scan aborted, no done pulse, outputs to reset values.
// STRUCTURE
//  - Shared package: state encoding localparams (ST_IDLE/ST_DRIVE/ST_EMIT/ST_DONE),
//    MODE_MINTERM=0 / MODE_MAXTERM=1.
//  - One sub-module: settle_counter (counts SETTLE cycles, clear + terminal-count output).
//  - FSM, index register and term counter stay in minterm_scanner.
// TESTING (function under test: SoP with minterms 2,4,7,11,12; N_VARS=4, SETTLE=1)
//  1 mode=0, idx_ready=1, start pulse -> idx 2,4,7,11,12 in order, count=5, done 1 cycle after 21 scan cycles.
//  2 mode=1 -> idx 0,1,3,5,6,8,9,10,13,14,15, count=11, done pulses once.
//  3 mode=0, idx_ready low 3 cycles at idx=7 -> idx=7, idx_valid=1, vars=7 stable; count stays 2 until accept.
//  4 f_in tied 0, mode=0 -> no idx_valid, count=0, done after 16 cycles; mode=1 -> count=16.
//  5 rst asserted mid-EMIT at idx=11 -> idx_valid/busy drop immediately, no done; next start rescans from 0.
//  6 start re-pulsed while busy and mode toggled mid-scan -> ignored, results identical to scenario 1.

Source files
------------

// File: rtl/minterm_scanner_pkg.sv
// Shared constants for the minterm/maxterm scanner: FSM state encodings and mode values.
package minterm_scanner_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic MODE_MINTERM = 1'b0;
    localparam logic MODE_MAXTERM = 1'b1;

endpackage

// File: rtl/minterm_scanner_settle.sv
// Settle-time counter: counts cycles a combination has been held, flags the final one.
module settle_counter
    import minterm_scanner_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(SETTLE - 1));

endmodule

// File: rtl/minterm_scanner.sv
// Enumerates all input combinations of a combinational function and streams out the
// indices of its minterms (mode 0) or maxterms (mode 1) over a valid/ready handshake.
module minterm_scanner
    import minterm_scanner_pkg::*;
#(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              f_in,
    output logic [N_VARS-1:0] vars,
    output logic              idx_valid,
    output logic [N_VARS-1:0] idx,
    input  logic              idx_ready,
    output logic              busy,
    output logic              done,
    output logic [N_VARS:0]   count
);

    localparam logic [N_VARS-1:0] LAST = '1;

    logic [1:0]        state;
    logic [N_VARS-1:0] m;
    logic              mode_q;
    logic              settle_tc;
    logic              settle_clear;

    // Counter restarts whenever a combination has been sampled or the FSM is outside DRIVE.
    assign settle_clear = (state != ST_DRIVE) || settle_tc;

    settle_counter #(
        .SETTLE(SETTLE)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .clear(settle_clear),
        .tc   (settle_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            m         <= '0;
            mode_q    <= MODE_MINTERM;
            idx       <= '0;
            idx_valid <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        m      <= '0;
                        count  <= '0;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle_tc) begin
                        // Equality compare so an unknown f_in never registers as a hit.
                        if (f_in != mode_q) begin
                            idx       <= m;
                            idx_valid <= 1'b1;
                            state     <= ST_EMIT;
                        end else if (m == LAST) begin
                            state <= ST_DONE;
                        end else begin
                            m <= m + N_VARS'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (idx_ready) begin
                        count     <= count + (N_VARS + 1)'(1);
                        idx_valid <= 1'b0;
                        if (m == LAST) begin
                            state <= ST_DONE;
                        end else begin
                            m     <= m + N_VARS'(1);
                            state <= ST_DRIVE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vars = m;
    assign busy = (state == ST_DRIVE) || (state == ST_EMIT);
    assign done = (state == ST_DONE);

endmodule
